cpu_regfile_write_arbiter: RTL

Shares the register file's single write port (we/wa/wd) among three write sources: ALU result, memory load data, and loop-counter update. Each source issues valid/grant-handshaked write requests. A round-robin arbiter picks one per cycle and drives a registered write command to the register file. Requests to addresses outside the 5-entry file (0..4) are consumed and flagged, never written.

---
 rtl/cpu_regfile_write_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/cpu_regfile_write_arbiter.sv
// cpu_regfile_write_arbiter
//
// Shares the register file's single write port among three write sources
// (0 = ALU result, 1 = memory load, 2 = loop-counter update). A round-robin
// arbiter grants at most one source per cycle. The granted request becomes a
// registered write command (we/wa/wd) one cycle later. A request whose
// address is outside the implemented file is consumed but never written, and
// it raises the sticky err_addr flag.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   hold       in   stall; no grant while high, round-robin pointer frozen
//   req_valid  in   [2:0] per-source request valid
//   req_addrN  in   [2:0] target register of source N
//   req_dataN  in   [7:0] write data of source N
//   err_clr    in   synchronous clear of err_addr (a same-cycle set wins)
//   gnt        out  [2:0] one-hot or zero combinational grant
//   we/wa/wd   out  registered write command to the register file
//   wsrc       out  [1:0] source that produced the last accepted command
//   err_addr   out  sticky out-of-range address flag
module cpu_regfile_write_arbiter #(
  parameter int NREGS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hold,
  input  logic [2:0] req_valid,
  input  logic [2:0] req_addr0,
  input  logic [2:0] req_addr1,
  input  logic [2:0] req_addr2,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  input  logic [7:0] req_data2,
  input  logic       err_clr,
  output logic [2:0] gnt,
  output logic       we,
  output logic [2:0] wa,
  output logic [7:0] wd,
  output logic [1:0] wsrc,
  output logic       err_addr
);

  localparam logic [3:0] NREGS_W = 4'(NREGS);

  logic [1:0] r_ptr;
  logic       r_we;
  logic [2:0] r_wa;
  logic [7:0] r_wd;
  logic [1:0] r_wsrc;
  logic       r_err;

  logic [2:0] w_rot;
  logic [1:0] w_off;
  logic [2:0] w_sum;
  logic [1:0] w_sel;
  logic       w_accept;
  logic [2:0] w_addr;
  logic [7:0] w_data;
  logic       w_bad;

  // Rotate the request vector so bit 0 is the source the pointer favours;
  // a fixed priority encoder on the rotated vector then gives round-robin.
  always_comb begin
    case (r_ptr)
      2'd1:    w_rot = {req_valid[0], req_valid[2], req_valid[1]};
      2'd2:    w_rot = {req_valid[1], req_valid[0], req_valid[2]};
      default: w_rot = req_valid;
    endcase
  end

  always_comb begin
    w_off = 2'd0;
    if (w_rot[0])      w_off = 2'd0;
    else if (w_rot[1]) w_off = 2'd1;
    else               w_off = 2'd2;
  end

  // Map the rotated winner back to a source index: (ptr + off) mod 3.
  assign w_sum    = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_sel    = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];

  // Grant is gated by reset so nothing is accepted while reset is asserted.
  assign w_accept = (|req_valid) & ~hold & ~reset;
  assign gnt      = w_accept ? (3'b001 << w_sel) : 3'b000;

  always_comb begin
    case (w_sel)
      2'd1:    begin w_addr = req_addr1; w_data = req_data1; end
      2'd2:    begin w_addr = req_addr2; w_data = req_data2; end
      default: begin w_addr = req_addr0; w_data = req_data0; end
    endcase
  end

  assign w_bad = ({1'b0, w_addr} >= NREGS_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr  <= 2'd0;
      r_we   <= 1'b0;
      r_wa   <= 3'd0;
      r_wd   <= 8'd0;
      r_wsrc <= 2'd0;
      r_err  <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_accept) begin
        r_ptr  <= (w_sel == 2'd2) ? 2'd0 : w_sel + 2'd1;
        r_wsrc <= w_sel;
        if (!w_bad) begin
          r_we <= 1'b1;
          r_wa <= w_addr;
          r_wd <= w_data;
        end
      end
      if (w_accept && w_bad) r_err <= 1'b1;
      else if (err_clr)      r_err <= 1'b0;
    end
  end

  assign we       = r_we;
  assign wa       = r_wa;
  assign wd       = r_wd;
  assign wsrc     = r_wsrc;
  assign err_addr = r_err;

endmodule
